// File: rtl/acs_node.sv
// Add-compare-select node for one trellis state of a hard-decision Viterbi decoder.
// Registered survivor metric and decision bit, with optional normalization after select.
module acs_node #(
  parameter int PM_W     = 8,
  parameter int STATE_ID = 0,
  parameter int NORM_TH  = 128,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             frame_start,
  input  logic             norm_en,
  input  logic [PM_W-1:0]  pm_a,
  input  logic [1:0]       bm_a,
  input  logic [PM_W-1:0]  pm_b,
  input  logic [1:0]       bm_b,
  output logic [PM_W-1:0]  pm_out,
  output logic             dec_bit,
  output logic             out_valid,
  output logic             norm_req,
  output logic [CNT_W-1:0] sym_cnt
);

  localparam logic [PM_W-1:0] PM_MAX  = {PM_W{1'b1}};
  localparam logic [PM_W-1:0] PM_INIT = (STATE_ID == 0) ? {PM_W{1'b0}} : PM_MAX;
  localparam logic [PM_W-1:0] TH      = PM_W'(NORM_TH);

  logic [PM_W:0]   sum_a_w;
  logic [PM_W:0]   sum_b_w;
  logic [PM_W-1:0] sum_a;
  logic [PM_W-1:0] sum_b;
  logic [PM_W-1:0] sel;
  logic            dec;
  logic [PM_W-1:0] pm_new;

  assign sum_a_w = {1'b0, pm_a} + {{(PM_W-1){1'b0}}, bm_a};
  assign sum_b_w = {1'b0, pm_b} + {{(PM_W-1){1'b0}}, bm_b};

  // Saturating adds keep the unreachable-state metric pinned at the ceiling.
  assign sum_a = sum_a_w[PM_W] ? PM_MAX : sum_a_w[PM_W-1:0];
  assign sum_b = sum_b_w[PM_W] ? PM_MAX : sum_b_w[PM_W-1:0];

  always_comb begin
    sel    = sum_a;
    dec    = 1'b0;
    pm_new = sum_a;
    if (sum_b < sum_a) begin
      sel = sum_b;
      dec = 1'b1;
    end
    pm_new = sel;
    if (norm_en && in_valid) begin
      pm_new = (sel >= TH) ? (sel - TH) : {PM_W{1'b0}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pm_out    <= PM_INIT;
      dec_bit   <= 1'b0;
      out_valid <= 1'b0;
      sym_cnt   <= '0;
    end else if (frame_start) begin
      // The symbol coincident with frame_start is intentionally dropped.
      pm_out    <= PM_INIT;
      dec_bit   <= 1'b0;
      out_valid <= 1'b0;
      sym_cnt   <= '0;
    end else if (in_valid) begin
      pm_out    <= pm_new;
      dec_bit   <= dec;
      out_valid <= 1'b1;
      sym_cnt   <= sym_cnt + 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign norm_req = (pm_out >= TH);

endmodule
